buzz_arbiter: RTL and testbench

Round controller for the four-person responder. It opens a buzz-in window when the host starts a round and latches the first valid player. It then holds that player's one-hot answer-enable (en_s0..en_s3) into the scoring block and runs the answer countdown. The round closes when the scoring block raises its interrupt (zd_r) or when the countdown expires. False starts are flagged, and the offending player is excluded for that round.

---
 rtl/buzz_arbiter.sv | 139 +++++++++++++
 tb/tb_buzz_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/buzz_arbiter.sv
// Round controller for the four-player responder. It opens the buzz window on the
// host start edge, latches the first eligible player and runs the answer countdown.
module buzz_arbiter #(
  parameter logic [3:0] ANS_TIME = 4'd9
) (
  input  logic       clk_count,
  input  logic       rst_n,
  input  logic       start,
  input  logic       s0,
  input  logic       s1,
  input  logic       s2,
  input  logic       s3,
  input  logic       tick,
  input  logic       zd_r,
  output logic       en_s0,
  output logic       en_s1,
  output logic       en_s2,
  output logic       en_s3,
  output logic [1:0] winner,
  output logic       armed,
  output logic [3:0] foul,
  output logic [3:0] countdown,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, ARMED, ANSWER, DONE} state_e;

  state_e     state_q, state_d;
  logic [3:0] s_prev_q;
  logic       start_prev_q;
  logic [3:0] en_q, en_d;
  logic [1:0] winner_q, winner_d;
  logic [3:0] foul_q, foul_d;
  logic [3:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;

  logic [3:0] buzz;
  logic [3:0] buzz_edge;
  logic [3:0] eligible;
  logic       start_edge;
  logic [1:0] pick;

  assign buzz       = {s3, s2, s1, s0};
  assign buzz_edge  = buzz & ~s_prev_q;
  assign start_edge = start & ~start_prev_q;
  assign eligible   = buzz_edge & ~foul_q;

  // Fixed priority: the lowest-index eligible player wins a same-cycle tie.
  always_comb begin
    if (eligible[0])      pick = 2'd0;
    else if (eligible[1]) pick = 2'd1;
    else if (eligible[2]) pick = 2'd2;
    else                  pick = 2'd3;
  end

  always_comb begin
    // NOTE: every next-state value defaults to its register, so no path infers a latch.
    state_d   = state_q;
    en_d      = en_q;
    winner_d  = winner_q;
    foul_d    = foul_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    unique case (state_q)
      IDLE: begin
        foul_d = foul_q | buzz_edge;
        if (start_edge) begin
          timeout_d = 1'b0;
          state_d   = ARMED;
        end
      end
      ARMED: begin
        if (foul_q == 4'hF) begin
          state_d = DONE;
        end else if (|eligible) begin
          en_d     = 4'b0001 << pick;
          winner_d = pick;
          cnt_d    = ANS_TIME;
          state_d  = ANSWER;
        end
      end
      ANSWER: begin
        // A judged answer beats an expiring tick in the same cycle.
        if (zd_r) begin
          state_d = DONE;
        end else if (tick) begin
          if (cnt_q == 4'd1) begin
            cnt_d     = 4'd0;
            timeout_d = 1'b1;
            state_d   = DONE;
          end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      DONE: begin
        en_d     = 4'b0000;
        winner_d = 2'd0;
        foul_d   = 4'b0000;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: synchronous reset; sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk_count) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      s_prev_q     <= 4'b0000;
      start_prev_q <= 1'b0;
      en_q         <= 4'b0000;
      winner_q     <= 2'd0;
      foul_q       <= 4'b0000;
      cnt_q        <= 4'd0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_prev_q     <= buzz;
      start_prev_q <= start;
      en_q         <= en_d;
      winner_q     <= winner_d;
      foul_q       <= foul_d;
      cnt_q        <= cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  assign en_s0     = en_q[0];
  assign en_s1     = en_q[1];
  assign en_s2     = en_q[2];
  assign en_s3     = en_q[3];
  assign winner    = winner_q;
  assign armed     = (state_q == ARMED);
  assign foul      = foul_q;
  assign countdown = cnt_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_buzz_arbiter.sv
// Directed bench for buzz_arbiter: stimulus pushes expected output snapshots into a
// queue and an independent monitor pops and compares them on the falling edge.
module tb_buzz_arbiter;

  typedef struct {
    string      name;
    logic [3:0] en;
    logic [1:0] winner;
    logic       armed;
    logic [3:0] foul;
    logic [3:0] cnt;
    logic       cnt_chk;
    logic       timeout;
  } exp_t;

  logic       clk_count = 1'b0;
  logic       rst_n     = 1'b0;
  logic       start     = 1'b0;
  logic [3:0] s         = 4'b0000;
  logic       tick      = 1'b0;
  logic       zd_r      = 1'b0;
  logic       en_s0, en_s1, en_s2, en_s3;
  logic [1:0] winner;
  logic       armed;
  logic [3:0] foul;
  logic [3:0] countdown;
  logic       timeout;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 1'b0;

  always #5 clk_count = ~clk_count;

  buzz_arbiter #(.ANS_TIME(4'd9)) dut (
    .clk_count (clk_count),
    .rst_n     (rst_n),
    .start     (start),
    .s0        (s[0]),
    .s1        (s[1]),
    .s2        (s[2]),
    .s3        (s[3]),
    .tick      (tick),
    .zd_r      (zd_r),
    .en_s0     (en_s0),
    .en_s1     (en_s1),
    .en_s2     (en_s2),
    .en_s3     (en_s3),
    .winner    (winner),
    .armed     (armed),
    .foul      (foul),
    .countdown (countdown),
    .timeout   (timeout)
  );

  task automatic cyc(input logic st, input logic [3:0] sv, input logic tk, input logic zd);
    start = st;
    s     = sv;
    tick  = tk;
    zd_r  = zd;
    @(posedge clk_count);
    #1;
  endtask

  task automatic expect_o(input string name, input logic [3:0] en, input logic [1:0] w,
                          input logic arm, input logic [3:0] f, input logic [3:0] c,
                          input logic c_chk, input logic to);
    exp_t e;
    e.name = name; e.en = en; e.winner = w; e.armed = arm; e.foul = f;
    e.cnt = c; e.cnt_chk = c_chk; e.timeout = to;
    exp_q.push_back(e);
  endtask

  task automatic check(input exp_t e);
    logic [3:0] en_act;
    logic       ok;
    en_act = {en_s3, en_s2, en_s1, en_s0};
    ok = (en_act === e.en) && (winner === e.winner) && (armed === e.armed) &&
         (foul === e.foul) && (timeout === e.timeout) &&
         (!e.cnt_chk || countdown === e.cnt);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got en=%b winner=%0d armed=%b foul=%b cnt=%0d timeout=%b; want en=%b winner=%0d armed=%b foul=%b cnt=%0d(chk=%b) timeout=%b",
               e.name, en_act, winner, armed, foul, countdown, timeout,
               e.en, e.winner, e.armed, e.foul, e.cnt, e.cnt_chk, e.timeout);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_count);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e);
      end
    end
  end

  initial begin : stimulus
    // Reset
    cyc(0, 4'b0000, 0, 0);
    cyc(0, 4'b0000, 0, 0);
    expect_o("reset", 4'b0000, 0, 0, 4'b0000, 0, 1, 0);
    rst_n = 1'b1;

    // Start, s2 buzzes in, zd_r closes the round
    cyc(1, 4'b0000, 0, 0);
    expect_o("start_arms", 4'b0000, 0, 1, 4'b0000, 0, 1, 0);
    cyc(1, 4'b0000, 0, 0);
    expect_o("start_held", 4'b0000, 0, 1, 4'b0000, 0, 1, 0);
    cyc(0, 4'b0100, 0, 0);
    expect_o("s2_latch", 4'b0100, 2, 0, 4'b0000, 9, 1, 0);
    cyc(0, 4'b0100, 0, 1);
    expect_o("zd_done_en_held", 4'b0100, 2, 0, 4'b0000, 9, 1, 0);
    cyc(0, 4'b0000, 0, 0);
    expect_o("zd_idle", 4'b0000, 0, 0, 4'b0000, 9, 1, 0);

    // s1 and s3 together: s1 wins, later s3 edge ignored
    cyc(1, 4'b0000, 0, 0);
    expect_o("r2_armed", 4'b0000, 0, 1, 4'b0000, 0, 0, 0);
    cyc(0, 4'b1010, 0, 0);
    expect_o("tie_s1", 4'b0010, 1, 0, 4'b0000, 9, 1, 0);
    cyc(0, 4'b0000, 0, 0);
    cyc(0, 4'b1000, 0, 0);
    expect_o("s3_ignored", 4'b0010, 1, 0, 4'b0000, 9, 1, 0);
    cyc(0, 4'b0000, 0, 1);
    cyc(0, 4'b0000, 0, 0);
    expect_o("r2_idle", 4'b0000, 0, 0, 4'b0000, 9, 1, 0);

    // False start by s0
    cyc(0, 4'b0001, 0, 0);
    expect_o("foul_s0", 4'b0000, 0, 0, 4'b0001, 9, 1, 0);
    cyc(0, 4'b0000, 0, 0);
    cyc(1, 4'b0000, 0, 0);
    expect_o("foul_armed", 4'b0000, 0, 1, 4'b0001, 0, 0, 0);
    cyc(0, 4'b0001, 0, 0);
    expect_o("s0_excluded", 4'b0000, 0, 1, 4'b0001, 0, 0, 0);
    cyc(0, 4'b1000, 0, 0);
    expect_o("s3_after_foul", 4'b1000, 3, 0, 4'b0001, 9, 1, 0);
    cyc(0, 4'b0000, 0, 1);
    expect_o("foul_done", 4'b1000, 3, 0, 4'b0001, 9, 1, 0);
    cyc(0, 4'b0000, 0, 0);
    expect_o("foul_cleared", 4'b0000, 0, 0, 4'b0000, 9, 1, 0);

    // Countdown expiry
    cyc(1, 4'b0000, 0, 0);
    cyc(0, 4'b0001, 0, 0);
    expect_o("exp_latch", 4'b0001, 0, 0, 4'b0000, 9, 1, 0);
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 4'b0000, 1, 0);
      expect_o($sformatf("tick_%0d", i), 4'b0001, 0, 0, 4'b0000, 4'(9 - i), 1, 0);
      if (i == 4) begin
        cyc(0, 4'b0000, 0, 0);
        expect_o("no_tick_hold", 4'b0001, 0, 0, 4'b0000, 5, 1, 0);
      end
    end
    cyc(0, 4'b0000, 1, 0);
    expect_o("expire_done", 4'b0001, 0, 0, 4'b0000, 0, 1, 1);
    cyc(0, 4'b0000, 0, 0);
    expect_o("expire_idle", 4'b0000, 0, 0, 4'b0000, 0, 1, 1);
    cyc(0, 4'b0000, 1, 0);
    expect_o("no_wrap", 4'b0000, 0, 0, 4'b0000, 0, 1, 1);

    // zd_r coincides with the expiring tick
    cyc(1, 4'b0000, 0, 0);
    expect_o("timeout_cleared", 4'b0000, 0, 1, 4'b0000, 0, 0, 0);
    cyc(0, 4'b0100, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 4'b0000, 1, 0);
    expect_o("cnt_at_1", 4'b0100, 2, 0, 4'b0000, 1, 1, 0);
    cyc(0, 4'b0000, 1, 1);
    expect_o("zd_wins_done", 4'b0100, 2, 0, 4'b0000, 1, 1, 0);
    cyc(0, 4'b0000, 0, 0);
    expect_o("zd_wins_idle", 4'b0000, 0, 0, 4'b0000, 1, 1, 0);

    // Everyone fouls: ARMED falls straight through DONE
    cyc(0, 4'b1111, 0, 0);
    cyc(0, 4'b0000, 0, 0);
    cyc(1, 4'b0000, 0, 0);
    expect_o("all_foul_armed", 4'b0000, 0, 1, 4'b1111, 1, 1, 0);
    cyc(0, 4'b0000, 0, 0);
    expect_o("all_foul_done", 4'b0000, 0, 0, 4'b1111, 1, 1, 0);
    cyc(0, 4'b0000, 0, 0);
    expect_o("all_foul_idle", 4'b0000, 0, 0, 4'b0000, 1, 1, 0);

    // Reset during ANSWER
    cyc(1, 4'b0000, 0, 0);
    cyc(0, 4'b0010, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 4'b0000, 1, 0);
    expect_o("pre_reset_cnt4", 4'b0010, 1, 0, 4'b0000, 4, 1, 0);
    rst_n = 1'b0;
    cyc(0, 4'b0000, 0, 0);
    expect_o("mid_reset", 4'b0000, 0, 0, 4'b0000, 0, 1, 0);
    rst_n = 1'b1;
    cyc(1, 4'b0000, 0, 0);
    expect_o("post_reset_armed", 4'b0000, 0, 1, 4'b0000, 0, 1, 0);
    cyc(0, 4'b0010, 0, 0);
    expect_o("post_reset_latch", 4'b0010, 1, 0, 4'b0000, 9, 1, 0);
    cyc(0, 4'b0000, 0, 1);
    cyc(0, 4'b0000, 0, 0);
    stim_done = 1'b1;
  end

  initial begin : finisher
    int budget;
    wait (stim_done);
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk_count);
      budget--;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: stimulus did not complete within time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $finish;
  end

endmodule
